inst_fetch: RTL

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch_if.sv | 31 +++
 rtl/inst_fetch.sv | 123 ++++++++++++
 2 files changed

// File: rtl/inst_fetch_if.sv
// rtl/inst_fetch_if.sv - fetch-stage bundle: instruction-memory request/ack plus decode-side handshake
interface inst_fetch_if;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemAck;
    logic [31:0] imemData;
    logic        inStall;
    logic        inRedirect;
    logic [31:0] inRedirectPC;
    logic        outValid;
    logic [31:0] outPC;
    logic [31:0] outInstr;
    logic [5:0]  outOpcode;
    logic [4:0]  outRs;
    logic [4:0]  outRt;
    logic [4:0]  outRd;
    logic [5:0]  outFunct;
    logic [15:0] outImm;

    modport master (
        output imemReq, imemAddr, outValid, outPC, outInstr,
               outOpcode, outRs, outRt, outRd, outFunct, outImm,
        input  imemAck, imemData, inStall, inRedirect, inRedirectPC
    );

    modport slave (
        input  imemReq, imemAddr, outValid, outPC, outInstr,
               outOpcode, outRs, outRt, outRd, outFunct, outImm,
        output imemAck, imemData, inStall, inRedirect, inRedirectPC
    );
endinterface

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - two-state instruction fetch stage with redirect; INST_FETCH_DELAY_SLOT_EN enables branch delay slot
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    inst_fetch_if.master  bus
);

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] redirect_pc;

    assign redirect_pc = {bus.inRedirectPC[31:2], 2'b00};

`ifdef INST_FETCH_DELAY_SLOT_EN
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_pc_q, pend_pc_d;
`endif

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        out_pc_d = out_pc_q;
`ifdef INST_FETCH_DELAY_SLOT_EN
        pend_valid_d = pend_valid_q;
        pend_pc_d    = pend_pc_q;
`endif
        case (state_q)
            FETCH: begin
`ifdef INST_FETCH_DELAY_SLOT_EN
                // The acked word is the delay slot; a pending or coincident target replaces PC+4.
                if (bus.imemAck) begin
                    instr_d      = bus.imemData;
                    out_pc_d     = pc_q;
                    state_d      = HOLD;
                    pend_valid_d = 1'b0;
                    if (bus.inRedirect)
                        pc_d = redirect_pc;
                    else if (pend_valid_q)
                        pc_d = pend_pc_q;
                    else
                        pc_d = pc_q + 32'd4;
                end else if (bus.inRedirect) begin
                    pend_valid_d = 1'b1;
                    pend_pc_d    = redirect_pc;
                end
`else
                if (bus.inRedirect) begin
                    pc_d = redirect_pc;
                end else if (bus.imemAck) begin
                    instr_d  = bus.imemData;
                    out_pc_d = pc_q;
                    pc_d     = pc_q + 32'd4;
                    state_d  = HOLD;
                end
`endif
            end
            HOLD: begin
`ifdef INST_FETCH_DELAY_SLOT_EN
                if (bus.inRedirect) begin
                    pend_valid_d = 1'b1;
                    pend_pc_d    = redirect_pc;
                end
                if (!bus.inStall)
                    state_d = FETCH;
`else
                // A redirect squashes the held word even when decode is stalled.
                if (bus.inRedirect) begin
                    pc_d    = redirect_pc;
                    state_d = FETCH;
                end else if (!bus.inStall) begin
                    state_d = FETCH;
                end
`endif
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            instr_q  <= 32'd0;
            out_pc_q <= 32'd0;
`ifdef INST_FETCH_DELAY_SLOT_EN
            pend_valid_q <= 1'b0;
            pend_pc_q    <= 32'd0;
`endif
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            out_pc_q <= out_pc_d;
`ifdef INST_FETCH_DELAY_SLOT_EN
            pend_valid_q <= pend_valid_d;
            pend_pc_q    <= pend_pc_d;
`endif
        end
    end

    assign bus.imemReq   = (state_q == FETCH) && !rst;
    assign bus.imemAddr  = pc_q;
    assign bus.outValid  = (state_q == HOLD);
    assign bus.outPC     = out_pc_q;
    assign bus.outInstr  = instr_q;
    assign bus.outOpcode = instr_q[31:26];
    assign bus.outRs     = instr_q[25:21];
    assign bus.outRt     = instr_q[20:16];
    assign bus.outRd     = instr_q[15:11];
    assign bus.outFunct  = instr_q[5:0];
    assign bus.outImm    = instr_q[15:0];

endmodule
